// File: rtl/clk_div_if.sv
// clk_div_if: divided-clock outputs (clk_out, tick, phase counter) bundled for clk_div.
interface clk_div_if #(parameter int DIV = 2);
  localparam int CW = $clog2(DIV);
  logic          clk_out;
  logic          tick;
  logic [CW-1:0] cnt;
  modport master (output clk_out, tick, cnt);
  modport slave  (input clk_out, tick, cnt);
endinterface

// File: rtl/clk_div.sv
// clk_div: integer clock divider with exact 50% duty for even and odd ratios.
module clk_div #(parameter int DIV = 2) (
  input logic        clk,
  input logic        reset,
  clk_div_if.master  o
);
  localparam int CW = $clog2(DIV);
  localparam int H  = DIV / 2;
  if (DIV < 2) begin : g_bad_div
    $error("clk_div: DIV must be >= 2");
  end
  logic [CW-1:0] cnt_q, cnt_nx;
  logic          pos_q;
  always_comb cnt_nx = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + CW'(1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_q <= '0;
      pos_q <= 1'b0;
    end else begin
      cnt_q <= cnt_nx;
      pos_q <= (cnt_nx >= CW'(DIV - H));
    end
  // odd ratios stretch the high phase by half a cycle with a falling-edge copy
  if (DIV % 2 == 1) begin : g_odd
    logic neg_q;
    always_ff @(negedge clk or posedge reset)
      if (reset) neg_q <= 1'b0;
      else       neg_q <= pos_q;
    assign o.clk_out = pos_q | neg_q;
  end else begin : g_even
    assign o.clk_out = pos_q;
  end
  assign o.cnt  = cnt_q;
  assign o.tick = (cnt_q == CW'(DIV - 1));
endmodule

// File: tb/tb_clk_div.sv
// tb_clk_div: checks clk_div at DIV=2,5,6,7 against vectors and a half-cycle phase model.
module tb_clk_div;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int k = 0;
  bit tbl_on = 1'b0;

  clk_div_if #(.DIV(2)) i2();
  clk_div_if #(.DIV(5)) i5();
  clk_div_if #(.DIV(6)) i6();
  clk_div_if #(.DIV(7)) i7();
  clk_div #(.DIV(2)) d2 (.clk(clk), .reset(reset), .o(i2));
  clk_div #(.DIV(5)) d5 (.clk(clk), .reset(reset), .o(i5));
  clk_div #(.DIV(6)) d6 (.clk(clk), .reset(reset), .o(i6));
  clk_div #(.DIV(7)) d7 (.clk(clk), .reset(reset), .o(i7));

  typedef struct {int d; int k; int half; int cnt; int co; int tk;} vec_t;
  vec_t vt[$];
  int divs[4] = '{2, 5, 6, 7};

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic sample(input int d, output int c, output int co, output int tk);
    case (d)
      2: begin c = int'(i2.cnt); co = int'(i2.clk_out); tk = int'(i2.tick); end
      5: begin c = int'(i5.cnt); co = int'(i5.clk_out); tk = int'(i5.tick); end
      6: begin c = int'(i6.cnt); co = int'(i6.clk_out); tk = int'(i6.tick); end
      default: begin c = int'(i7.cnt); co = int'(i7.clk_out); tk = int'(i7.tick); end
    endcase
  endtask

  // clk_out is high for DIV half-cycles starting at the rising edge where cnt becomes DIV-H
  function automatic int exp_co(input int d, input int kk, input int half);
    int rise = 2 * (d - d / 2);
    int p = 2 * (kk % d) + half;
    return (((p - rise + 2 * d) % (2 * d)) < d) ? 1 : 0;
  endfunction

  task automatic check_model(input int kk, input int half);
    int c, co, tk;
    foreach (divs[i]) begin
      sample(divs[i], c, co, tk);
      chk($sformatf("div%0d k%0d h%0d cnt", divs[i], kk, half), c, kk % divs[i]);
      chk($sformatf("div%0d k%0d h%0d clk_out", divs[i], kk, half), co, exp_co(divs[i], kk, half));
      chk($sformatf("div%0d k%0d h%0d tick", divs[i], kk, half), tk, (kk % divs[i] == divs[i] - 1) ? 1 : 0);
    end
    if (tbl_on)
      foreach (vt[j])
        if (vt[j].k == kk && vt[j].half == half) begin
          sample(vt[j].d, c, co, tk);
          chk($sformatf("vec%0d div%0d cnt", j, vt[j].d), c, vt[j].cnt);
          chk($sformatf("vec%0d div%0d clk_out", j, vt[j].d), co, vt[j].co);
          chk($sformatf("vec%0d div%0d tick", j, vt[j].d), tk, vt[j].tk);
        end
  endtask

  task automatic check_reset(input string tag);
    int c, co, tk;
    foreach (divs[i]) begin
      sample(divs[i], c, co, tk);
      chk($sformatf("%s div%0d cnt", tag, divs[i]), c, 0);
      chk($sformatf("%s div%0d clk_out", tag, divs[i]), co, 0);
      chk($sformatf("%s div%0d tick", tag, divs[i]), tk, 0);
    end
  endtask

  task automatic run(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      k++;
      #1 check_model(k, 0);
      @(negedge clk);
      #1 check_model(k, 1);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    k = 0;
  endtask

  initial begin
    int c6[12]  = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 0};
    int co6[12] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
    int c, co, tk, hi, ticks, mx;
    for (int i = 0; i < 12; i++)
      vt.push_back('{6, i + 1, 0, c6[i], co6[i], (c6[i] == 5) ? 1 : 0});
    vt.push_back('{5, 2, 1, 2, 0, 0});
    vt.push_back('{5, 3, 0, 3, 1, 0});
    vt.push_back('{5, 4, 0, 4, 1, 1});
    vt.push_back('{5, 5, 0, 0, 1, 0});
    vt.push_back('{5, 5, 1, 0, 0, 0});
    vt.push_back('{5, 8, 1, 3, 1, 0});
    vt.push_back('{2, 1, 0, 1, 1, 1});
    vt.push_back('{2, 2, 0, 0, 0, 0});
    vt.push_back('{2, 3, 1, 1, 1, 1});

    #3 reset = 1'b1;
    #1 check_reset("por");
    repeat (2) @(posedge clk);
    #1 check_reset("por_hold");
    release_reset();
    tbl_on = 1'b1;
    run(12);
    tbl_on = 1'b0;

    // async reset in the middle of a DIV=6 high phase with cnt=4
    reset = 1'b1;
    #1 check_reset("rst2");
    release_reset();
    run(4);
    #2 reset = 1'b1;
    #1 sample(6, c, co, tk);
    chk("midphase div6 cnt", c, 0);
    chk("midphase div6 clk_out", co, 0);
    check_reset("midphase");
    release_reset();
    run(8);

    // DIV=7: 100 periods of 14 half-cycle samples each
    run((7 - k % 7) % 7);
    for (int p = 0; p < 100; p++) begin
      hi = 0; ticks = 0; mx = 0;
      repeat (7) begin
        @(posedge clk);
        k++;
        #1 sample(7, c, co, tk);
        hi += co; ticks += tk; mx = (c > mx) ? c : mx;
        @(negedge clk);
        #1 sample(7, c, co, tk);
        hi += co; mx = (c > mx) ? c : mx;
      end
      chk($sformatf("div7 period%0d high_halves", p), hi, 7);
      chk($sformatf("div7 period%0d ticks", p), ticks, 1);
      chk($sformatf("div7 period%0d cnt_max_ok", p), (mx <= 6) ? 1 : 0, 1);
    end

    // random run lengths interrupted by async resets at random points
    for (int it = 0; it < 30; it++) begin
      run($urandom_range(1, 40));
      #($urandom_range(1, 3)) reset = 1'b1;
      #1 check_reset($sformatf("rnd%0d", it));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1 check_reset($sformatf("rnd%0d_hold", it));
      release_reset();
    end
    run(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
